linescanner_capture_controller: RTL and testbench

//   Sequences the linescanner image capture unit across one frame: exposure delay, line readout, line/frame framing.

---
 rtl/linescanner_pkg.sv | 32 +++
 rtl/capture_sync_fifo.sv | 57 +++++
 rtl/linescanner_capture_controller.sv | 184 ++++++++++++++++++
 tb/tb_linescanner_capture_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linescanner_pkg.sv
// rtl/linescanner_pkg.sv - shared types, FIFO word layout and sizing helper for the linescanner capture controller
package linescanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXPOSE  = 3'd1,
        ST_READOUT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    // Framing flags sit in the low bits of each FIFO word, pixel data above them.
    localparam int FLAG_SOL  = 0;
    localparam int FLAG_EOL  = 1;
    localparam int FLAG_EOF  = 2;
    localparam int FLAG_BITS = 3;

    // Ceiling log2, never below 1 so the result can always size a vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/capture_sync_fifo.sv
// rtl/capture_sync_fifo.sv - synchronous pixel FIFO with flush and simultaneous push/pop at full
// Ports: clk, n_reset (sync, active-low), flush, push/push_data, pop/pop_data (first-word
// fall-through, stable until popped), full, empty. DEPTH must be a power of two, >= 2.
module capture_sync_fifo
    import linescanner_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!n_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/linescanner_capture_controller.sv
// rtl/linescanner_capture_controller.sv - frame sequencer for the linescanner capture unit
// Ports: main_clock_source, n_reset (sync, active-low); start_frame/abort control;
// sensor_enable, pixel_captured, pixel_data to/from the capture unit; out_* valid/ready
// pixel stream with SOL/EOL/EOF; line_index, busy, frame_done status; sticky error flags.
module linescanner_capture_controller
    import linescanner_pkg::*;
#(
    parameter int PIXEL_WIDTH     = 8,
    parameter int PIXELS_PER_LINE = 1024,
    parameter int LINES_PER_FRAME = 512,
    parameter int EXPOSURE_CYCLES = 64,
    parameter int LINE_TIMEOUT    = 4096,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                main_clock_source,
    input  logic                                n_reset,
    input  logic                                start_frame,
    input  logic                                abort,
    output logic                                sensor_enable,
    input  logic                                pixel_captured,
    input  logic [PIXEL_WIDTH-1:0]              pixel_data,
    output logic [PIXEL_WIDTH-1:0]              out_pixel_data,
    output logic                                out_sol,
    output logic                                out_eol,
    output logic                                out_eof,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [clog2(LINES_PER_FRAME)-1:0]   line_index,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                error_timeout,
    output logic                                error_overflow
);

    localparam int PW     = clog2(PIXELS_PER_LINE);
    localparam int LW     = clog2(LINES_PER_FRAME);
    localparam int EW     = clog2(EXPOSURE_CYCLES);
    localparam int TW     = clog2(LINE_TIMEOUT);
    localparam int WORD_W = PIXEL_WIDTH + FLAG_BITS;

    state_t            state;
    state_t            next_state;
    logic [EW-1:0]     expose_cnt;
    logic [TW-1:0]     timeout_cnt;
    logic [PW-1:0]     pixel_cnt;
    logic [WORD_W-1:0] push_word;
    logic [WORD_W-1:0] pop_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_flush;
    logic              strobe;
    logic              overflow_hit;
    logic              timeout_hit;
    logic              accept;
    logic              last_pixel;
    logic              last_line;
    logic              start_accept;

    assign strobe       = (state == ST_READOUT) && pixel_captured;
    // Full FIFO only overflows if the consumer is not taking a word this same cycle.
    assign overflow_hit = strobe && fifo_full && !out_ready;
    assign accept       = strobe && !overflow_hit;
    assign timeout_hit  = (state == ST_READOUT) && !pixel_captured
                          && (timeout_cnt == TW'(LINE_TIMEOUT - 1));
    assign last_pixel   = (pixel_cnt == PW'(PIXELS_PER_LINE - 1));
    assign last_line    = (line_index == LW'(LINES_PER_FRAME - 1));
    assign start_accept = start_frame && !abort && (state == ST_IDLE || state == ST_ERROR);

    // State register
    always_ff @(posedge main_clock_source) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start_frame) next_state = ST_EXPOSE;
                ST_EXPOSE:  if (expose_cnt == EW'(EXPOSURE_CYCLES - 1)) next_state = ST_READOUT;
                ST_READOUT: begin
                    if (overflow_hit || timeout_hit) begin
                        next_state = ST_ERROR;
                    end else if (accept && last_pixel) begin
                        next_state = last_line ? ST_DRAIN : ST_EXPOSE;
                    end
                end
                ST_DRAIN:   if (fifo_empty) next_state = ST_DONE;
                ST_DONE:    next_state = ST_IDLE;
                ST_ERROR:   if (start_frame) next_state = ST_EXPOSE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        sensor_enable  = (state == ST_READOUT);
        busy           = (state != ST_IDLE);
        frame_done     = (state == ST_DONE);
        out_valid      = !fifo_empty;
        out_pixel_data = '0;
        out_sol        = 1'b0;
        out_eol        = 1'b0;
        out_eof        = 1'b0;
        if (!fifo_empty) begin
            out_pixel_data = pop_word[WORD_W-1:FLAG_BITS];
            out_sol        = pop_word[FLAG_SOL];
            out_eol        = pop_word[FLAG_EOL];
            out_eof        = pop_word[FLAG_EOF];
        end
    end

    // Counters and sticky error flags
    always_ff @(posedge main_clock_source) begin
        if (!n_reset) begin
            expose_cnt     <= '0;
            timeout_cnt    <= '0;
            pixel_cnt      <= '0;
            line_index     <= '0;
            error_timeout  <= 1'b0;
            error_overflow <= 1'b0;
        end else begin
            expose_cnt  <= (state == ST_EXPOSE && next_state == ST_EXPOSE)
                           ? expose_cnt + 1'b1 : '0;
            timeout_cnt <= (state == ST_READOUT && next_state == ST_READOUT && !pixel_captured)
                           ? timeout_cnt + 1'b1 : '0;

            // Leaving the frame (abort, error, drain) discards any partial line position.
            if (next_state != ST_READOUT && next_state != ST_EXPOSE) begin
                pixel_cnt <= '0;
            end else if (accept) begin
                pixel_cnt <= last_pixel ? '0 : pixel_cnt + 1'b1;
            end

            if (start_accept || next_state == ST_IDLE) begin
                line_index <= '0;
            end else if (accept && last_pixel && !last_line) begin
                line_index <= line_index + 1'b1;
            end

            if (start_accept) begin
                error_timeout  <= 1'b0;
                error_overflow <= 1'b0;
            end else if (!abort) begin
                if (timeout_hit) error_timeout <= 1'b1;
                if (overflow_hit) error_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        push_word                          = '0;
        push_word[WORD_W-1:FLAG_BITS]      = pixel_data;
        push_word[FLAG_SOL]                = (pixel_cnt == '0);
        push_word[FLAG_EOL]                = last_pixel;
        push_word[FLAG_EOF]                = last_pixel && last_line;
    end

    // Flushing on the transition into ERROR means the stream is already empty in ERROR.
    assign fifo_flush = abort || (state == ST_ERROR) || (next_state == ST_ERROR);

    capture_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (main_clock_source),
        .n_reset   (n_reset),
        .flush     (fifo_flush),
        .push      (accept),
        .push_data (push_word),
        .pop       (out_ready),
        .pop_data  (pop_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_linescanner_capture_controller.sv
// tb/tb_linescanner_capture_controller.sv - directed self-checking bench for linescanner_capture_controller
module tb_linescanner_capture_controller;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       start_frame = 1'b0;
    logic       abort = 1'b0;
    logic       pixel_captured = 1'b0;
    logic [7:0] pixel_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       sensor_enable;
    logic [7:0] out_pixel_data;
    logic       out_sol, out_eol, out_eof, out_valid;
    logic [0:0] line_index;
    logic       busy, frame_done, error_timeout, error_overflow;

    always #5 clk = ~clk;

    linescanner_capture_controller #(
        .PIXEL_WIDTH     (8),
        .PIXELS_PER_LINE (4),
        .LINES_PER_FRAME (2),
        .EXPOSURE_CYCLES (3),
        .LINE_TIMEOUT    (16),
        .FIFO_DEPTH      (4)
    ) dut (
        .main_clock_source (clk),
        .n_reset           (n_reset),
        .start_frame       (start_frame),
        .abort             (abort),
        .sensor_enable     (sensor_enable),
        .pixel_captured    (pixel_captured),
        .pixel_data        (pixel_data),
        .out_pixel_data    (out_pixel_data),
        .out_sol           (out_sol),
        .out_eol           (out_eol),
        .out_eof           (out_eof),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .line_index        (line_index),
        .busy              (busy),
        .frame_done        (frame_done),
        .error_timeout     (error_timeout),
        .error_overflow    (error_overflow)
    );

    typedef struct {
        logic       start;
        logic       strobe;
        logic [7:0] data;
        logic       en;
        logic       bsy;
        logic       vld;
        logic       dn;
        logic       ln;
    } vec_t;

    vec_t        vecs [18];
    logic [10:0] got [$];
    int          tests = 0;
    int          failed = 0;
    int          done_cnt = 0;
    int          hi;

    function automatic vec_t mk(input logic s, input logic st, input logic [7:0] d,
                                input logic en, input logic b, input logic v,
                                input logic dn, input logic ln);
        vec_t r;
        r.start = s; r.strobe = st; r.data = d;
        r.en = en; r.bsy = b; r.vld = v; r.dn = dn; r.ln = ln;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge; a transfer is recorded if the coming
    // rising edge will see valid and ready, and frame_done is counted afterwards.
    task automatic cycle();
        #1;
        if (out_valid && out_ready) got.push_back({out_pixel_data, out_eof, out_eol, out_sol});
        @(negedge clk);
        if (frame_done) done_cnt++;
    endtask

    task automatic wait_enable(input string name);
        for (int n = 0; n < 20 && !sensor_enable; n++) cycle();
        check({name, "_enable_seen"}, sensor_enable, 1);
    endtask

    task automatic capture_line(input string name, input logic [7:0] base);
        wait_enable(name);
        for (int i = 0; i < 4; i++) begin
            pixel_captured = 1'b1;
            pixel_data     = base + 8'(i);
            cycle();
        end
        pixel_captured = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 40 && done_cnt == 0; n++) cycle();
        check({name, "_frame_done_count"}, done_cnt, 1);
    endtask

    task automatic check_stream(input string name, input logic [7:0] base);
        check({name, "_count"}, got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            logic [10:0] e;
            e = {base + 8'(i), (i == 7), (i % 4 == 3), (i % 4 == 0)};
            check($sformatf("%s_px%0d", name, i), got[i], e);
        end
    endtask

    initial begin
        //           start strobe data   en bsy vld dn ln
        vecs[0]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 8'h10, 1, 1, 1, 0, 0);
        vecs[5]  = mk(0, 1, 8'h11, 1, 1, 1, 0, 0);
        vecs[6]  = mk(0, 1, 8'h12, 1, 1, 1, 0, 0);
        vecs[7]  = mk(0, 1, 8'h13, 0, 1, 1, 0, 1);
        vecs[8]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 1);
        vecs[9]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 1);
        vecs[10] = mk(0, 0, 8'h00, 1, 1, 0, 0, 1);
        vecs[11] = mk(0, 1, 8'h14, 1, 1, 1, 0, 1);
        vecs[12] = mk(0, 1, 8'h15, 1, 1, 1, 0, 1);
        vecs[13] = mk(0, 1, 8'h16, 1, 1, 1, 0, 1);
        vecs[14] = mk(0, 1, 8'h17, 0, 1, 1, 0, 1);
        vecs[15] = mk(0, 0, 8'h00, 0, 1, 0, 0, 1);
        vecs[16] = mk(0, 0, 8'h00, 0, 1, 0, 1, 1);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0);

        // Reset held for two clocks
        cycle();
        cycle();
        check("rst_enable", sensor_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_stream", {out_pixel_data, out_sol, out_eol, out_eof}, 0);
        check("rst_status", {frame_done, error_timeout, error_overflow, line_index}, 0);

        // Reset glitch between edges must not disturb a running frame
        n_reset     = 1'b1;
        start_frame = 1'b1;
        cycle();
        start_frame = 1'b0;
        #1 n_reset = 1'b0;
        #2 n_reset = 1'b1;
        cycle();
        check("glitch_busy", busy, 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("glitch_abort_idle", busy, 0);

        // Full frame, cycle by cycle
        out_ready = 1'b1;
        got.delete();
        done_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            start_frame    = vecs[i].start;
            pixel_captured = vecs[i].strobe;
            pixel_data     = vecs[i].data;
            cycle();
            check($sformatf("ff%0d_enable", i), sensor_enable, vecs[i].en);
            check($sformatf("ff%0d_busy", i), busy, vecs[i].bsy);
            check($sformatf("ff%0d_valid", i), out_valid, vecs[i].vld);
            check($sformatf("ff%0d_done", i), frame_done, vecs[i].dn);
            check($sformatf("ff%0d_line", i), line_index, vecs[i].ln);
        end
        check_stream("ff_stream", 8'h10);
        check("ff_done_once", done_cnt, 1);

        // Backpressure: line 0 fills the FIFO exactly, head word held stable
        got.delete();
        done_cnt    = 0;
        out_ready   = 1'b0;
        start_frame = 1'b1;
        cycle();
        start_frame = 1'b0;
        capture_line("bp_l0", 8'h20);
        check("bp_full_valid", out_valid, 1);
        check("bp_head", {out_pixel_data, out_sol}, {8'h20, 1'b1});
        cycle();
        cycle();
        check("bp_head_stable", {out_pixel_data, out_sol}, {8'h20, 1'b1});
        check("bp_no_overflow", error_overflow, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("bp_drained", out_valid, 0);
        out_ready = 1'b0;
        capture_line("bp_l1", 8'h24);
        for (int i = 0; i < 5; i++) cycle();
        check("bp_drain_waits_busy", busy, 1);
        check("bp_drain_waits_valid", out_valid, 1);
        check("bp_drain_no_done", done_cnt, 0);
        out_ready = 1'b1;
        wait_done("bp");
        check_stream("bp_stream", 8'h20);
        cycle();
        check("bp_idle_after", busy, 0);

        // Overflow: consumer never ready, 5th strobe overflows
        got.delete();
        out_ready   = 1'b0;
        start_frame = 1'b1;
        cycle();
        start_frame = 1'b0;
        capture_line("ov_l0", 8'h30);
        check("ov_no_flag_at_four", error_overflow, 0);
        capture_line("ov_l1", 8'h34);
        check("ov_flag", error_overflow, 1);
        check("ov_no_timeout", error_timeout, 0);
        check("ov_busy_error", busy, 1);
        check("ov_valid_flushed", out_valid, 0);
        check("ov_enable_low", sensor_enable, 0);
        cycle();
        cycle();
        check("ov_stays_error", {busy, sensor_enable, error_overflow}, 3'b101);

        // Timeout: restart from ERROR, then starve READOUT of strobes
        start_frame = 1'b1;
        cycle();
        start_frame = 1'b0;
        check("to_restart_clears_overflow", error_overflow, 0);
        check("to_restart_busy", busy, 1);
        wait_enable("to");
        hi = 0;
        while (sensor_enable && hi < 40) begin
            hi++;
            cycle();
        end
        check("to_readout_cycles", hi, 16);
        check("to_flag", error_timeout, 1);
        check("to_enable_low", sensor_enable, 0);
        check("to_busy_error", busy, 1);

        // Abort together with start_frame in the middle of READOUT
        done_cnt    = 0;
        start_frame = 1'b1;
        cycle();
        start_frame = 1'b0;
        check("ab_restart_clears_timeout", error_timeout, 0);
        wait_enable("ab");
        pixel_captured = 1'b1;
        pixel_data     = 8'h40;
        cycle();
        pixel_data = 8'h41;
        cycle();
        check("ab_fifo_has_data", out_valid, 1);
        abort       = 1'b1;
        start_frame = 1'b1;
        pixel_data  = 8'h42;
        cycle();
        abort          = 1'b0;
        start_frame    = 1'b0;
        pixel_captured = 1'b0;
        check("ab_idle", busy, 0);
        check("ab_fifo_empty", out_valid, 0);
        check("ab_line_zero", line_index, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("ab_still_idle", busy, 0);
        check("ab_no_done", done_cnt, 0);

        // A fresh frame after abort starts cleanly at pixel 0
        got.delete();
        out_ready   = 1'b1;
        start_frame = 1'b1;
        cycle();
        start_frame = 1'b0;
        capture_line("re_l0", 8'h50);
        capture_line("re_l1", 8'h54);
        wait_done("re");
        check_stream("re_stream", 8'h50);
        cycle();
        check("re_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
